// File: rtl/shift_unit_pipe.sv
// ---------------------------------------------------------------------------
// shift_unit_pipe
// Two-stage pipelined RV32I shift execution unit (SLL/SRL/SRA and the
// immediate forms). It uses a single left barrel shifter for every op.
// Right shifts reverse the operand bits before the shifter, reverse the
// result back afterwards, and OR in the sign fill for SRA.
//
// Ports
//   clk          system clock, rising-edge
//   rst          synchronous active-high reset (priority over everything)
//   flush        synchronous pipeline kill; drops both stages
//   in_valid     request valid
//   in_ready     unit accepts a request this cycle (combinational)
//   in_op        00 SLL, 01 SRL, 11 SRA, 10 reserved (runs as SLL, flagged)
//   in_data      rs1 operand
//   in_amt       shift amount 0..31
//   in_tag       destination register tag
//   out_valid    result valid
//   out_ready    consumer accepts result
//   out_data     shift result
//   out_tag      tag travelling with the result
//   out_illegal  result came from the reserved op encoding
// ---------------------------------------------------------------------------

// 32-bit logarithmic left shifter. It has five conditional shift levels.
module barrel_shifter_left_32 (
    input  logic [31:0] data_i,
    input  logic [4:0]  amt_i,
    output logic [31:0] data_o
);
    logic [31:0] lvl;

    always_comb begin
        lvl = data_i;
        for (int i = 0; i < 5; i++) begin
            if (amt_i[i]) lvl = lvl << (1 << i);
        end
        data_o = lvl;
    end
endmodule

module shift_unit_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_data,
    input  logic [4:0]       in_amt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    localparam logic [1:0] OP_SRA = 2'b11;
    localparam logic [1:0] OP_RSV = 2'b10;

    function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = x[XLEN-1-i];
        return r;
    endfunction

    // Top amt bits set: the positions vacated by a right shift of amt.
    function automatic logic [XLEN-1:0] sign_fill(input logic [4:0] amt);
        return ~({XLEN{1'b1}} >> amt);
    endfunction

    // Control state
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;

    // Stage-1 payload
    logic [1:0]       s1_op_q;
    logic [4:0]       s1_amt_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s1_sign_q;
    logic [XLEN-1:0]  s1_pre_q;

    // Stage-2 payload (the output register)
    logic [XLEN-1:0]  out_data_q,    out_data_d;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_illegal_q, out_illegal_d;

    logic s2_adv, s1_adv, accept;
    logic [XLEN-1:0] shifted;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = (!s1_valid_q || s2_adv) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (flush)       s1_valid_d = 1'b0;
        else if (accept) s1_valid_d = 1'b1;
        else if (s1_adv) s1_valid_d = 1'b0;

        s2_valid_d = s2_valid_q;
        if (flush)       s2_valid_d = 1'b0;
        else if (s2_adv) s2_valid_d = s1_valid_q;
    end

    // ---- stage 0 -> stage 1: capture operands, pre-reverse for right shifts
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op_q   <= in_op;
            s1_amt_q  <= in_amt;
            s1_tag_q  <= in_tag;
            s1_sign_q <= in_data[XLEN-1];
            s1_pre_q  <= in_op[0] ? bitrev(in_data) : in_data;
        end
    end

    barrel_shifter_left_32 u_shl (
        .data_i (s1_pre_q),
        .amt_i  (s1_amt_q),
        .data_o (shifted)
    );

    always_comb begin
        out_data_d = s1_op_q[0] ? bitrev(shifted) : shifted;
        if (s1_op_q == OP_SRA && s1_sign_q) out_data_d = out_data_d | sign_fill(s1_amt_q);
        out_illegal_d = (s1_op_q == OP_RSV);
    end

    // ---- stage 1 -> stage 2: output register, held while consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            out_data_q    <= '0;
            out_tag_q     <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            // Flush leaves payload untouched; only the valid bits are killed.
            if (s1_adv && !flush) begin
                out_data_q    <= out_data_d;
                out_tag_q     <= s1_tag_q;
                out_illegal_q <= out_illegal_d;
            end
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_data    = out_data_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_illegal_q;
endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Two-stage pipelined RV32I shift execution unit (SLL/SRL/SRA, and the immediate forms SLLI/SRLI/SRAI) with a valid/ready handshake on both sides.
- Sits in the execute stage between the decode/operand-issue stage and the writeback arbiter.
- Internally it feeds the team's 32-bit left barrel shifter (barrel_shifter_left_32).
- Right shifts are produced by bit-reversing the operand before the left shifter, reversing the result back, and OR-ing in sign fill for SRA.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TAG_W, 5, width of the destination-register tag carried alongside the data.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous pipeline kill (branch mispredict/trap)
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- in_op  in  2  00 SLL, 01 SRL, 11 SRA, 10 reserved
- in_data  in  32  rs1 operand
- in_amt  in  5  shift amount (rs2[4:0] or shamt)
- in_tag  in  TAG_W  destination register tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  32  shift result
- out_tag  out  TAG_W  tag of the result
- out_illegal  out  1  result came from reserved op 10

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high.
  - rst has priority over flush and over all handshakes.
  - On rst: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_tag=0, out_illegal=0. in_ready=1 in the first cycle after rst deasserts.
- Handshake:
  - Input transfer when in_valid&&in_ready.
  - Output transfer when out_valid&&out_ready.
  - While out_valid=1 and out_ready=0, out_data/out_tag/out_illegal are held stable.
  - in_valid/in_data are not required to be stable before acceptance.
- Pipeline:
  - Stage 1 register captures: op, amt, tag, sign=in_data[31], and pre = (op[0] ? bitrev(in_data) : in_data).
  - Combinational path from the stage-1 register: shifted = barrel_shifter_left_32(pre, amt).
  - Stage 2 register (the output register) captures res = op[0] ? bitrev(shifted) : shifted.
  - If op==11 and sign==1, res |= ~(32'hFFFFFFFF >> amt).
  - Op 10 executes as SLL and sets out_illegal=1.
- Latency and throughput:
  - Accept in cycle N -> out_valid in cycle N+2 when there is no stall.
  - Throughput is 1 result per cycle.
- Stall logic:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = s1_valid && s2_adv
  - in_ready = (!s1_valid || s2_adv) && !flush
  - in_ready is combinational from out_ready.
  - No bubbles are inserted when the pipeline is full and out_ready=1.
- Stage-2 update on s2_adv: s2_valid <= s1_valid, and the payload loads from stage 1. When stage 1 is empty, the payload keeps its old value (don't-care data, valid=0).
- Flush:
  - Clears s1_valid and s2_valid on the next edge. Payload registers are unchanged.
  - A request presented in the same cycle is not accepted (in_ready=0).
  - A result with out_valid&&out_ready in the flush cycle counts as transferred.
- Arithmetic rules:
  - amt=0 passes data unchanged for all ops.
  - amt=31 is the maximum; no amt>31 exists.
  - SRA fill uses bit 31 of the original operand only.
- Ordering: results leave in acceptance order; no loss or duplication.

Test Plan:
- Basic SLL: SLL in_data=0x0000_0001 amt=31, out_ready=1 → out_valid exactly 2 cycles after accept, out_data=0x8000_0000, out_illegal=0.
- SRL vs SRA on a negative operand: SRL 0x8000_0000 amt=4 → 0x0800_0000. SRA 0x8000_0000 amt=4 → 0xF800_0000. SRA 0x7FFF_FFFF amt=31 → 0x0000_0000. SRA 0xFFFF_FFFF amt=0 → 0xFFFF_FFFF.
- Reserved op: op=10, in_data=0x0000_00F0, amt=8, tag=7 → out_data=0x0000_F000, out_illegal=1, out_tag=7.
- Back-pressure:
  - Stimulus: issue tags 1,2,3 back-to-back; hold out_ready=0 from cycle 2 to cycle 6.
  - Required response: tag1 is held stable on the output; in_ready drops once both stages are full.
  - After release, tags 1,2,3 emerge on consecutive cycles, in order, with no duplicates.
- Flush with full pipeline: both stages valid, flush=1 with in_valid=1 → in_ready=0 in that cycle, out_valid=0 the next cycle, and the flushed tags never appear.
- Reset mid-operation:
  - Stimulus: rst=1 for 1 cycle while stage 2 holds an unaccepted result.
  - Required response: out_valid=0, out_data=0, out_tag=0 after the edge; in_ready=1 the following cycle.
  - A new SLL 0x1 amt=1 then produces 0x2 with 2-cycle latency.
